ram: RTL and testbench

- Single-port synchronous-write, combinational-read 32-bit data memory for the core; serves as instruction/data RAM in simulation and FPGA builds.
- Byte-sized capacity set by MEM_SIZE. Word accesses only; the address is a byte address.
- Asynchronous active-low reset clears the whole array.
- Out-of-range and misaligned accesses are flagged.

---
 rtl/ram.sv | 42 ++++
 tb/tb_ram.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-port word memory: synchronous write, combinational read, byte addressing.
// Flags out-of-range and misaligned accesses; async reset clears the whole array.
module ram #(
    parameter int unsigned MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        addr_err,
    output logic        misaligned
);

    localparam int unsigned WORDS = MEM_SIZE / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]      mem [WORDS];
    logic [29:0]      word_idx;
    logic [IDX_W-1:0] slot;

    // Full 30-bit word index is range-checked so high addresses never alias low words.
    assign word_idx   = addr[31:2];
    assign slot       = word_idx[IDX_W-1:0];
    assign addr_err   = (word_idx >= 30'(WORDS));
    assign misaligned = |addr[1:0];

    assign data_out = addr_err ? 32'h0 : mem[slot];

    // Storage: cleared asynchronously, written on the rising edge when in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (we && !addr_err) begin
            mem[slot] <= data_in;
        end
    end

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: expected read results go through a scoreboard queue
// and are compared against the combinational outputs away from clock edges.
module tb_ram;

    localparam int unsigned MEM_SIZE = 128;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        addr_err;
    logic        misaligned;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    ram #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .we         (we),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_err   (addr_err),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [31:0] d, input logic e, input logic m);
        exp_t x;
        x.tag = tag; x.data = d; x.err = e; x.mis = m;
        sb.push_back(x);
    endtask

    // Pops the oldest expectation and compares it with the present outputs.
    task automatic compare_out();
        exp_t x;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1 entry");
        end else begin
            x = sb.pop_front();
            checks++;
            assert (data_out === x.data) else begin
                errors++;
                $error("FAIL %s data_out observed=%h expected=%h", x.tag, data_out, x.data);
            end
            checks++;
            assert (addr_err === x.err) else begin
                errors++;
                $error("FAIL %s addr_err observed=%b expected=%b", x.tag, addr_err, x.err);
            end
            checks++;
            assert (misaligned === x.mis) else begin
                errors++;
                $error("FAIL %s misaligned observed=%b expected=%b", x.tag, misaligned, x.mis);
            end
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic e, input logic m);
        we   = 1'b0;
        addr = a;
        expect_out(tag, d, e, m);
        #1;
        compare_out();
    endtask

    // Drives a write after the falling edge, checks old data before the rising edge
    // and the expected data right after it.
    task automatic write_chk(input string tag, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [31:0] old_d,
                             input logic [31:0] new_d, input logic e, input logic m);
        @(negedge clk);
        addr    = a;
        we      = w;
        data_in = d;
        expect_out({tag, "_pre"}, old_d, e, m);
        #1;
        compare_out();
        expect_out({tag, "_post"}, new_d, e, m);
        @(posedge clk);
        #1;
        compare_out();
        we = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b1;
        addr    = 32'h0;
        we      = 1'b0;
        data_in = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        read_chk("reset_w0", 32'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        write_chk("wr0", 32'd0, 1'b1, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0);
        read_chk("rd0", 32'd0, 32'h12345678, 1'b0, 1'b0);

        write_chk("wr4", 32'd4, 1'b1, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        write_chk("wr124", 32'd124, 1'b1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        read_chk("rd0b", 32'd0, 32'h12345678, 1'b0, 1'b0);
        read_chk("rd4", 32'd4, 32'hA5A5A5A5, 1'b0, 1'b0);
        read_chk("rd124", 32'd124, 32'hDEADBEEF, 1'b0, 1'b0);
        read_chk("rd8_unwritten", 32'd8, 32'h0, 1'b0, 1'b0);

        write_chk("wr128_oor", 32'd128, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0);
        read_chk("rd0_after_oor", 32'd0, 32'h12345678, 1'b0, 1'b0);
        read_chk("rd124_after_oor", 32'd124, 32'hDEADBEEF, 1'b0, 1'b0);
        write_chk("wr_hi_oor", 32'h80000000, 1'b1, 32'h0BADF00D, 32'h0, 32'h0, 1'b1, 1'b0);
        read_chk("rd0_no_alias", 32'd0, 32'h12345678, 1'b0, 1'b0);
        read_chk("rd_hi_mis", 32'h80000003, 32'h0, 1'b1, 1'b1);

        write_chk("wr6_mis", 32'd6, 1'b1, 32'h11223344, 32'hA5A5A5A5, 32'h11223344, 1'b0, 1'b1);
        read_chk("rd4_after_mis", 32'd4, 32'h11223344, 1'b0, 1'b0);
        read_chk("rd5_mis", 32'd5, 32'h11223344, 1'b0, 1'b1);
        read_chk("rd127_mis", 32'd127, 32'hDEADBEEF, 1'b0, 1'b1);

        write_chk("wr0_we0", 32'd0, 1'b0, 32'hCAFEBABE, 32'h12345678, 32'h12345678, 1'b0, 1'b0);

        // Reset asserted between edges clears visible data immediately.
        @(negedge clk);
        addr = 32'd4;
        #2 rst_n = 1'b0;
        #1;
        read_chk("rst_async_w1", 32'd4, 32'h0, 1'b0, 1'b0);
        read_chk("rst_async_w31", 32'd124, 32'h0, 1'b0, 1'b0);
        addr    = 32'd0;
        we      = 1'b1;
        data_in = 32'hFEEDFACE;
        @(posedge clk);
        #1;
        read_chk("rst_blocks_write", 32'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(MEM_SIZE / 4); i++) begin
            read_chk($sformatf("post_rst_w%0d", i), 32'(i * 4), 32'h0, 1'b0, 1'b0);
        end

        write_chk("wr_after_rst", 32'd8, 1'b1, 32'h5A5A0F0F, 32'h0, 32'h5A5A0F0F, 1'b0, 1'b0);
        read_chk("rd0_after_rst", 32'd0, 32'h0, 1'b0, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
